// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with one-cycle logic/compare/shift ops and
// iterative shift-add multiply and restoring divide, valid/ready on both sides.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [SHW-1:0] step;
  logic [3:0] op_q;
  logic [WIDTH-1:0] a_q, hi, lo, opnd;
  logic b_zero, neg_q, neg_r;
  logic accept, is_long, is_mul, is_sdiv, mul_q, div_ok;
  logic [WIDTH-1:0] fast, hi_n, lo_n, long_res;
  logic [WIDTH:0] mul_sum, div_sh, div_diff;
  assign accept  = in_valid && in_ready;
  assign is_long = op[3] & (op[2] | op[1]);
  assign is_mul  = op[3:1] == 3'b101;
  assign is_sdiv = (op[3:2] == 2'b11) & ~op[0];
  assign mul_q   = op_q[3:1] == 3'b101;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = in_valid ? (is_long ? CALC : DONE) : IDLE;
      CALC:    state_n = (step == LAST) ? DONE : CALC;
      DONE:    state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
  end
  always_comb begin
    fast = '0;
    case (op)
      4'd0:    fast = a + b;
      4'd1:    fast = a - b;
      4'd2:    fast = a ^ b;
      4'd3:    fast = a | b;
      4'd4:    fast = a & b;
      4'd5:    fast = a << b[SHW-1:0];
      4'd6:    fast = a >> b[SHW-1:0];
      4'd7:    fast = $unsigned($signed(a) >>> b[SHW-1:0]);
      4'd8:    fast = WIDTH'($signed(a) < $signed(b));
      4'd9:    fast = WIDTH'(a < b);
      default: fast = '0;
    endcase
  end
  // hi/lo double as product halves (multiply) or remainder/quotient (divide)
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_sh   = {hi, lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_ok   = ~div_diff[WIDTH];
    hi_n     = mul_q ? mul_sum[WIDTH:1] : (div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]);
    lo_n     = mul_q ? {mul_sum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], div_ok};
    long_res = mul_q ? (op_q[0] ? hi_n : lo_n)
             : !op_q[1] ? (b_zero ? '1 : (neg_q ? -lo_n : lo_n))
             : (b_zero ? a_q : (neg_r ? -hi_n : hi_n));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      step   <= '0;
      op_q   <= '0;
      a_q    <= '0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      b_zero <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
    end else if (accept) begin
      step   <= '0;
      op_q   <= op;
      a_q    <= a;
      b_zero <= b == '0;
      neg_q  <= is_sdiv & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= is_sdiv & a[WIDTH-1];
      hi     <= '0;
      lo     <= is_mul ? b : ((is_sdiv & a[WIDTH-1]) ? -a : a);
      opnd   <= is_mul ? a : ((is_sdiv & b[WIDTH-1]) ? -b : b);
      if (!is_long) begin
        result <= fast;
        zero   <= fast == '0;
      end
    end else if (state == CALC) begin
      step <= step + 1'b1;
      hi   <= hi_n;
      lo   <= lo_n;
      if (step == LAST) begin
        result <= long_res;
        zero   <= long_res == '0;
      end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors into a scoreboard queue; a forked monitor pops
// and checks result, zero and latency whenever out_valid first appears.
module tb_seq_alu;
  localparam int W = 32;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 1;
  logic [3:0] op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, zero, busy;
  logic [W-1:0] result;
  typedef struct {logic [W-1:0] res; logic z; int acc; int lat;} exp_t;
  typedef struct {logic [3:0] o; logic [W-1:0] x; logic [W-1:0] y; logic [W-1:0] r;} vec_t;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0;
  bit seen = 0;
  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic void chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endfunction
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] r);
    int n = 0;
    exp_t e;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    in_valid = 1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 0; op = ~o; a = ~x; b = ~y;
    e.res = r; e.z = (r == '0); e.acc = cyc; e.lat = (o >= 4'd10) ? W + 1 : 1;
    q.push_back(e);
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (q.size() != 0 || out_valid) chk("drain_timeout", W'(q.size()), 0);
  endtask
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) seen = 0;
      else begin
        if (out_valid && !seen) begin
          seen = 1;
          if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
          else begin
            e = q.pop_front();
            chk("result", result, e.res);
            chk("zero", W'(zero), W'(e.z));
            chk("latency", W'(cyc - e.acc + 1), W'(e.lat));
          end
        end
        if (out_valid && out_ready) seen = 0;
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t vecs[$] = '{
      '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000},
      '{4'd1,  32'h00000005, 32'h00000005, 32'h00000000},
      '{4'd2,  32'hF0F00000, 32'h0FF000FF, 32'hFF0000FF},
      '{4'd3,  32'h00000012, 32'h00000021, 32'h00000033},
      '{4'd4,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00},
      '{4'd5,  32'h00000001, 32'h00000024, 32'h00000010},
      '{4'd6,  32'h80000000, 32'h0000001F, 32'h00000001},
      '{4'd7,  32'h80000000, 32'h00000021, 32'hC0000000},
      '{4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001},
      '{4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000},
      '{4'd10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE},
      '{4'd11, 32'hFFFFFFFF, 32'h00000002, 32'h00000001},
      '{4'd10, 32'h00003039, 32'h000003E8, 32'h00BC5EA8},
      '{4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
      '{4'd12, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD},
      '{4'd14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF},
      '{4'd13, 32'h00000009, 32'h00000000, 32'hFFFFFFFF},
      '{4'd15, 32'h00000009, 32'h00000000, 32'h00000009},
      '{4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
      '{4'd14, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
      '{4'd12, 32'h00000007, 32'h00000000, 32'hFFFFFFFF},
      '{4'd14, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9},
      '{4'd13, 32'h00000064, 32'h00000007, 32'h0000000E},
      '{4'd15, 32'h00000064, 32'h00000007, 32'h00000002},
      '{4'd12, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD},
      '{4'd14, 32'h00000007, 32'hFFFFFFFE, 32'h00000001}
    };
    fork monitor(); join_none
    #1 rst = 1;
    #1;
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_result", result, 0);
    chk("rst_zero", W'(zero), 1);
    @(posedge clk); #1;
    rst = 0;
    foreach (vecs[i]) issue(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].r);
    drain();
    out_ready = 0;
    issue(4'd2, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); op = 4'd0; a = 32'd1; b = 32'd1;
      chk("hold_result", result, 32'hAAAAAAAA);
      chk("hold_in_ready", W'(in_ready), 0);
      chk("hold_out_valid", W'(out_valid), 1);
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk("release_in_ready", W'(in_ready), 1);
    chk("release_out_valid", W'(out_valid), 0);
    drain();
    in_valid = 1; op = 4'd13; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (9) @(posedge clk);
    #1;
    chk("calc_busy", W'(busy), 1);
    chk("calc_in_ready", W'(in_ready), 0);
    rst = 1;
    #1;
    chk("arst_out_valid", W'(out_valid), 0);
    chk("arst_busy", W'(busy), 0);
    chk("arst_in_ready", W'(in_ready), 1);
    chk("arst_result", result, 0);
    chk("arst_zero", W'(zero), 1);
    @(posedge clk); #1;
    rst = 0;
    issue(4'd0, 32'd2, 32'd3, 32'd5);
    drain();
    repeat (40) @(posedge clk);
    #1;
    chk("queue_empty", W'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
